conv_adder_tree: RTL
====================

Name: conv_adder_tree

Overview:
- Pipelined signed reduction stage that consumes the KERNEL_SIZE**2 product vector produced by the convolver's multiplier.
- Sums all products plus a per-window bias and emits one DATA_WIDTH fixed-point convolution result per accepted window.
- Valid/ready streaming on both sides, with stall-capable pipeline registers.
- Sits between the multiplier and the activation/output buffer.

Parameters:
- DATA_WIDTH, 16, width of each product, the bias and the result (signed, Q(DATA_WIDTH-FRAC_BIT).FRAC_BIT).
- KERNEL_SIZE, 5, kernel edge; number of products N = KERNEL_SIZE**2.
- FRAC_BIT, 8, fractional bits; informational only, since the sum needs no rescale.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  product vector and bias are valid.
- in_ready  output  1  block accepts input this cycle.
- products  input  N*DATA_WIDTH  packed signed products; element j is at [j*DATA_WIDTH +: DATA_WIDTH].
- bias  input  DATA_WIDTH  signed bias, sampled with products.
- out_valid  output  1  out_sum is valid.
- out_ready  input  1  downstream accepts out_sum.
- out_sum  output  DATA_WIDTH  signed result.

Behaviour:
- Reset (synchronous, active-high) clears every stage valid bit, out_valid=0 and out_sum=0. Data registers may also clear.
- Reset mid-stream discards all in-flight windows. The first window accepted after reset deasserts is the first one produced.
- Internal width: SUM_W = DATA_WIDTH + ceil(log2(N+1)), which is 21 bits for the defaults. Each product and the bias are sign-extended to SUM_W.
- Tree structure:
  - LEVELS = ceil(log2(N)) registered adder levels; 5 for the defaults.
  - Each level adds adjacent pairs. An odd leftover passes through, added to zero.
  - Bias travels alongside in a delay register.
- Final stage: adds the bias, then applies saturation or wrap (see Optional Feature) into the out_sum register.
- Latency: LATENCY = LEVELS + 1 cycles from the accepting edge to out_valid, i.e. 6 cycles for the defaults.
- Global advance enable: en = !out_valid || out_ready.
  - in_ready = en, a combinational function of out_valid and out_ready.
  - When en=1, every stage's data and valid shift forward one level.
  - When en=0, all stages hold.
- Input acceptance: a transfer occurs when in_valid && in_ready. If in_valid=0 while en=1, a bubble (valid=0) enters level 0.
- Bubbles are not compressed. Throughput is 1 window/cycle while out_ready=1.
- Output holds out_sum and out_valid stable while out_valid && !out_ready.
- Simultaneous output handshake and new input in the same cycle is allowed, with no loss and no duplication.
- Results leave in strict acceptance order.

Optional Feature:
- Macro: CONV_ADDER_TREE_SAT_EN.
- Defined: the final SUM_W result clamps to the signed DATA_WIDTH range.
  - Values above 2^(DATA_WIDTH-1)-1 give 0x7FFF.
  - Values below -2^(DATA_WIDTH-1) give 0x8000.
- Undefined: out_sum = low DATA_WIDTH bits of the result (two's-complement wrap), and no clamp logic is built.

Decomposition:
- Shared package conv_pkg:
  - DATA_WIDTH, KERNEL_SIZE and FRAC_BIT defaults.
  - Function clog2.
  - Derived constants N, SUM_W, LEVELS and LATENCY.
  - Typedef for the signed SUM_W accumulator word.
- One sub-module: conv_add_level. It is parameterised by input count and width, and implements one registered pairwise-add level with valid and enable. The top instantiates LEVELS copies via generate.

Test Plan:
- All 25 products = 0x0100 (1.0), bias = 0x0000, out_ready=1 -> out_sum = 0x1900 (25.0), out_valid exactly 6 cycles after acceptance.
- products[j] = j (raw) for j=0..24, bias = 0xFFFF -> out_sum = 0x012B (300-1).
- All products = 0x7FFF, bias = 0 -> 0x7FFF with CONV_ADDER_TREE_SAT_EN, 0x7FE7 without. All products = 0x8000 -> 0x8000 in both builds.
- Backpressure: 8 back-to-back windows with sums 1..8 while out_ready is low for 3 cycles mid-stream.
  - in_ready drops in the same cycle out_ready blocks a valid output.
  - Outputs 1..8 appear in order, no drops or duplicates.
  - out_sum stays stable while stalled.
- Reset asserted for 1 cycle with 4 windows in flight -> out_valid=0 and out_sum=0 next cycle, and none of the 4 results appear. A window accepted after reset emerges after 6 cycles.
- in_valid toggling every other cycle with out_ready=1 -> outputs alternate valid/bubble at the 6-cycle latency, with correct sums.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, sizing helpers and accumulator type for the convolver adder tree.
package conv_pkg;

   localparam int DATA_WIDTH  = 16;
   localparam int KERNEL_SIZE = 5;
   localparam int FRAC_BIT    = 8;

   // Ceiling log2; clog2(1) is 0
   function automatic int clog2(input int value);
      int result;
      int span;
      result = 32'sd0;
      span   = 32'sd1;
      while (span < value) begin
         span   = span * 32'sd2;
         result = result + 32'sd1;
      end
      return result;
   endfunction

   // Number of operands entering a given tree level when the tree starts with n operands
   function automatic int level_count(input int n, input int level);
      int cnt;
      cnt = n;
      for (int i = 0; i < level; i++) begin
         cnt = (cnt + 32'sd1) / 32'sd2;
      end
      return cnt;
   endfunction

   localparam int N       = KERNEL_SIZE * KERNEL_SIZE;
   localparam int SUM_W   = DATA_WIDTH + clog2(N + 1);
   localparam int LEVELS  = clog2(N);
   localparam int LATENCY = LEVELS + 1;

   typedef logic signed [SUM_W-1:0] acc_t;

endpackage

// File: rtl/conv_add_level.sv
// One registered pairwise-add level of the reduction tree; an odd leftover operand passes through.
module conv_add_level
   import conv_pkg::*;
#(
   parameter int IN_CNT = 25,
   parameter int W = 21,
   localparam int OUT_CNT = (IN_CNT + 1) / 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 in_valid,
   input  logic [IN_CNT*W-1:0]  in_data,
   output logic                 out_valid,
   output logic [OUT_CNT*W-1:0] out_data
);

   logic [OUT_CNT*W-1:0] sum_s;
   logic [OUT_CNT*W-1:0] data_r;
   logic                 valid_r;

   for (genvar i = 0; i < OUT_CNT; i++) begin : g_pair
      if (2 * i + 1 < IN_CNT) begin : g_add
         assign sum_s[i*W +: W] = in_data[(2*i)*W +: W] + in_data[(2*i+1)*W +: W];
      end else begin : g_pass
         assign sum_s[i*W +: W] = in_data[(2*i)*W +: W] + {W{1'b0}};
      end
   end

   // Level register: shifts data and valid together when the pipeline advances
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_r <= 1'b0;
         data_r  <= {(OUT_CNT*W){1'b0}};
      end else if (en) begin
         valid_r <= in_valid;
         data_r  <= sum_s;
      end
   end

   assign out_valid = valid_r;
   assign out_data  = data_r;

endmodule

// File: rtl/conv_adder_tree.sv
// Pipelined signed sum of KERNEL_SIZE**2 products plus bias with valid/ready on both sides.
// Define CONV_ADDER_TREE_SAT_EN to clamp the result to the DATA_WIDTH range instead of wrapping.
module conv_adder_tree
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH  = conv_pkg::DATA_WIDTH,
   parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
   parameter int FRAC_BIT    = conv_pkg::FRAC_BIT
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] products,
   input  logic [DATA_WIDTH-1:0]                       bias,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [DATA_WIDTH-1:0]                       out_sum
);

   localparam int TREE_N      = KERNEL_SIZE * KERNEL_SIZE;
   localparam int TREE_W      = DATA_WIDTH + clog2(TREE_N + 1);
   localparam int TREE_LEVELS = clog2(TREE_N);
   // Products and result share one Q format, so the fraction position never matters here
   localparam int unused_frac_bit = FRAC_BIT;

   logic                      en_s;
   logic [TREE_N*TREE_W-1:0]  ext_s;
   logic [TREE_W-1:0]         tree_s;
   logic                      tree_valid_s;
   logic [DATA_WIDTH-1:0]     bias_r [TREE_LEVELS];
   logic signed [TREE_W-1:0]  bias_ext_s;
   logic signed [TREE_W-1:0]  total_s;
   logic [DATA_WIDTH-1:0]     result_s;
   logic                      out_valid_r;
   logic [DATA_WIDTH-1:0]     out_sum_r;

   // The whole pipeline advances only when the output register is free or being drained
   assign en_s     = !out_valid_r || out_ready;
   assign in_ready = en_s;

   for (genvar j = 0; j < TREE_N; j++) begin : g_ext
      assign ext_s[j*TREE_W +: TREE_W] =
         {{(TREE_W-DATA_WIDTH){products[j*DATA_WIDTH+DATA_WIDTH-1]}}, products[j*DATA_WIDTH +: DATA_WIDTH]};
   end

   for (genvar l = 0; l < TREE_LEVELS; l++) begin : g_lvl
      localparam int IC = level_count(TREE_N, l);
      localparam int OC = (IC + 1) / 2;
      logic [IC*TREE_W-1:0] din_s;
      logic                 vin_s;
      logic [OC*TREE_W-1:0] dout_s;
      logic                 vout_s;

      if (l == 0) begin : g_src
         assign din_s = ext_s;
         assign vin_s = in_valid;
      end else begin : g_chain
         assign din_s = g_lvl[l-1].dout_s;
         assign vin_s = g_lvl[l-1].vout_s;
      end

      conv_add_level #(
         .IN_CNT (IC),
         .W      (TREE_W)
      ) u_level (
         .clk       (clk),
         .reset     (reset),
         .en        (en_s),
         .in_valid  (vin_s),
         .in_data   (din_s),
         .out_valid (vout_s),
         .out_data  (dout_s)
      );
   end

   assign tree_s       = g_lvl[TREE_LEVELS-1].dout_s;
   assign tree_valid_s = g_lvl[TREE_LEVELS-1].vout_s;

   // Bias delay line keeps each window's bias aligned with its partial sums
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TREE_LEVELS; i++) begin
            bias_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (en_s) begin
         bias_r[0] <= bias;
         for (int i = 1; i < TREE_LEVELS; i++) begin
            bias_r[i] <= bias_r[i-1];
         end
      end
   end

   assign bias_ext_s =
      {{(TREE_W-DATA_WIDTH){bias_r[TREE_LEVELS-1][DATA_WIDTH-1]}}, bias_r[TREE_LEVELS-1]};

`ifdef CONV_ADDER_TREE_SAT_EN
   localparam logic signed [TREE_W-1:0] SAT_HI =
      {{(TREE_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [TREE_W-1:0] SAT_LO =
      {{(TREE_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   // Final add and clamp into the signed DATA_WIDTH range
   always_comb begin
      total_s = $signed(tree_s) + bias_ext_s;
      if (total_s > SAT_HI) begin
         result_s = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (total_s < SAT_LO) begin
         result_s = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
         result_s = total_s[DATA_WIDTH-1:0];
      end
   end
`else
   logic [TREE_W-DATA_WIDTH-1:0] unused_hi_s;

   // Final add with two's-complement wrap into DATA_WIDTH
   always_comb begin
      total_s                 = $signed(tree_s) + bias_ext_s;
      {unused_hi_s, result_s} = total_s;
   end
`endif

   // Output register holds its value while downstream stalls
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         out_sum_r   <= {DATA_WIDTH{1'b0}};
      end else if (en_s) begin
         out_valid_r <= tree_valid_s;
         out_sum_r   <= result_s;
      end
   end

   assign out_valid = out_valid_r;
   assign out_sum   = out_sum_r;

endmodule
